exc_ctrl: RTL and testbench

Exception/interrupt controller for the 5-stage MIPS core. It commits exceptions at the M stage. It takes the per-instruction exception code from the exception pipeline, combines it with hardware and timer interrupts, and updates the CP0 registers (BadVAddr, Count, Compare, Status, Cause, EPC). It then sequences a one-cycle pipeline flush with a redirect PC for both exception entry and `eret`.

---
 rtl/exc_ctrl_pkg.sv | 43 ++++
 rtl/exc_ctrl_timer.sv | 67 ++++++
 rtl/exc_ctrl.sv | 167 ++++++++++++++++
 tb/tb_exc_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller.
// Holds the ExcCode values, the CP0 register numbers, the Status/Cause bit positions,
// the flush FSM state type and a small helper for address-error codes.
package exc_ctrl_pkg;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // CP0 register numbers
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // Status / Cause bit positions
  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IM_LO = 8;
  localparam int unsigned STATUS_BEV   = 22;
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_BD     = 31;

  typedef enum logic [1:0] {
    StRun,
    StFlushExc,
    StFlushEret
  } exc_state_e;

  // Only address errors latch BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/exc_ctrl_timer.sv
// CP0 Count/Compare timer.
// Ports: clk, reset (async active-low), count_we/compare_we/wdata (mtc0 write ports),
// count, compare (current values), timer_irq (set on Count==Compare after an increment,
// held until Compare is written).
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_irq
);

  localparam int unsigned DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [31:0]   count_q, count_d, compare_q, compare_d;
  logic          irq_q, irq_d;
  logic          tick;

  assign tick = (div_q == DW'(COUNT_DIV - 1));

  always_comb begin
    div_d     = div_q;
    count_d   = count_q;
    compare_d = compare_q;
    irq_d     = irq_q;
    if (count_we) begin
      count_d = wdata;
      div_d   = '0;
    end else if (tick) begin
      div_d   = '0;
      count_d = count_q + 32'd1;
      if (count_d == compare_q) irq_d = 1'b1;
    end else begin
      div_d = div_q + DW'(1);
    end
    // A Compare write acknowledges the timer, even against a same-cycle match.
    if (compare_we) begin
      compare_d = wdata;
      irq_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      irq_q     <= irq_d;
    end
  end

  assign count     = count_q;
  assign compare   = compare_q;
  assign timer_irq = irq_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller committing at the M stage.
// Ports: clk, reset (async active-low); M-stage inputs m_valid, stall_M, exc_code_M, pc_M,
// bd_M, badvaddr_M, eret_M; hw_int (level interrupts); cp0_we/cp0_addr/cp0_wdata (mtc0);
// cp0_rdata (combinational mfc0 read); req/target_pc (registered one-cycle flush and
// redirect); epc_out (current EPC).
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int unsigned COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic        stall_M,
  input  logic [4:0]  exc_code_M,
  input  logic [31:0] pc_M,
  input  logic        bd_M,
  input  logic [31:0] badvaddr_M,
  input  logic        eret_M,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        req,
  output logic [31:0] target_pc,
  output logic [31:0] epc_out
);

  exc_state_e  state_q;
  logic        req_q;
  logic [31:0] target_pc_q;

  logic [7:0]  status_im_q;
  logic        status_exl_q, status_ie_q;
  logic        cause_bd_q;
  logic [5:0]  cause_ip_hw_q;
  logic [1:0]  cause_ip_sw_q;
  logic [4:0]  cause_exc_q;
  logic [31:0] epc_q, badvaddr_q;

  logic [31:0] count, compare;
  logic        timer_irq;
  logic        unused_hw_int5;

  logic        take, int_pend, take_int, take_exc, take_eret, entry, wr_en;
  logic [4:0]  entry_code;
  logic [31:0] status_word, cause_word;

  assign unused_hw_int5 = hw_int[5];

  // Only RUN can commit; M-stage inputs during a flush are wrong-path.
  assign take       = m_valid & ~stall_M & (state_q == StRun);
  assign int_pend   = status_ie_q & ~status_exl_q &
                      (|({cause_ip_hw_q, cause_ip_sw_q} & status_im_q));
  assign take_int   = take & int_pend;
  assign take_exc   = take & ~int_pend & (exc_code_M != EXC_INT);
  assign take_eret  = take & ~int_pend & (exc_code_M == EXC_INT) & eret_M;
  assign entry      = take_int | take_exc;
  assign wr_en      = take & cp0_we & ~int_pend & (exc_code_M == EXC_INT) & ~eret_M;
  assign entry_code = take_int ? EXC_INT : exc_code_M;

  cp0_timer #(
    .COUNT_DIV(COUNT_DIV)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .count_we  (wr_en && (cp0_addr == CP0_COUNT)),
    .compare_we(wr_en && (cp0_addr == CP0_COMPARE)),
    .wdata     (cp0_wdata),
    .count     (count),
    .compare   (compare),
    .timer_irq (timer_irq)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_im_q   <= '0;
      status_exl_q  <= 1'b0;
      status_ie_q   <= 1'b0;
      cause_bd_q    <= 1'b0;
      cause_ip_hw_q <= '0;
      cause_ip_sw_q <= '0;
      cause_exc_q   <= '0;
      epc_q         <= '0;
      badvaddr_q    <= '0;
    end else begin
      cause_ip_hw_q <= {timer_irq, hw_int[4:0]};
      if (entry) begin
        cause_exc_q  <= entry_code;
        // Nested exceptions keep the original return point.
        if (!status_exl_q) begin
          epc_q      <= bd_M ? (pc_M - 32'd4) : pc_M;
          cause_bd_q <= bd_M;
        end
        status_exl_q <= 1'b1;
        if (take_exc && is_addr_exc(exc_code_M)) badvaddr_q <= badvaddr_M;
      end else if (take_eret) begin
        status_exl_q <= 1'b0;
      end else if (wr_en) begin
        case (cp0_addr)
          CP0_STATUS: begin
            status_im_q  <= cp0_wdata[STATUS_IM_LO +: 8];
            status_exl_q <= cp0_wdata[STATUS_EXL];
            status_ie_q  <= cp0_wdata[STATUS_IE];
          end
          CP0_CAUSE: cause_ip_sw_q <= cp0_wdata[CAUSE_IP_LO +: 2];
          CP0_EPC:   epc_q         <= cp0_wdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      req_q       <= 1'b0;
      target_pc_q <= '0;
    end else begin
      case (state_q)
        StRun: begin
          if (entry) begin
            state_q     <= StFlushExc;
            req_q       <= 1'b1;
            target_pc_q <= EXC_VECTOR;
          end else if (take_eret) begin
            state_q     <= StFlushEret;
            req_q       <= 1'b1;
            target_pc_q <= epc_q;
          end
        end
        default: begin
          state_q <= StRun;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    status_word = '0;
    status_word[STATUS_BEV]          = 1'b1;
    status_word[STATUS_IM_LO +: 8]   = status_im_q;
    status_word[STATUS_EXL]          = status_exl_q;
    status_word[STATUS_IE]           = status_ie_q;
    cause_word = '0;
    cause_word[CAUSE_BD]             = cause_bd_q;
    cause_word[CAUSE_IP_LO +: 8]     = {cause_ip_hw_q, cause_ip_sw_q};
    cause_word[CAUSE_EXC_LO +: 5]    = cause_exc_q;
    case (cp0_addr)
      CP0_BADVADDR: cp0_rdata = badvaddr_q;
      CP0_COUNT:    cp0_rdata = count;
      CP0_COMPARE:  cp0_rdata = compare;
      CP0_STATUS:   cp0_rdata = status_word;
      CP0_CAUSE:    cp0_rdata = cause_word;
      CP0_EPC:      cp0_rdata = epc_q;
      default:      cp0_rdata = '0;
    endcase
  end

  assign req       = req_q;
  assign target_pc = target_pc_q;
  assign epc_out   = epc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: a word-level CP0 model is updated on each clock edge,
// and one compare process checks the DUT against it every cycle, plus literal checks.
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_valid, stall_M, bd_M, eret_M, cp0_we;
  logic [4:0]  exc_code_M, cp0_addr;
  logic [31:0] pc_M, badvaddr_M, cp0_wdata;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rdata, target_pc, epc_out;
  logic        req;

  exc_ctrl #(
    .EXC_VECTOR(VEC),
    .COUNT_DIV (DIV)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .m_valid   (m_valid),
    .stall_M   (stall_M),
    .exc_code_M(exc_code_M),
    .pc_M      (pc_M),
    .bd_M      (bd_M),
    .badvaddr_M(badvaddr_M),
    .eret_M    (eret_M),
    .hw_int    (hw_int),
    .cp0_we    (cp0_we),
    .cp0_addr  (cp0_addr),
    .cp0_wdata (cp0_wdata),
    .cp0_rdata (cp0_rdata),
    .req       (req),
    .target_pc (target_pc),
    .epc_out   (epc_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model (whole CP0 words) ----------------
  logic [31:0] m_status, m_cause, m_epc, m_bad, m_count, m_compare, m_tgt;
  logic        m_tirq, m_req;
  int          m_div;
  logic        md_take, md_ipend, md_cwe, md_cmpwe, md_old_tirq;
  logic [4:0]  md_code;
  logic [31:0] md_old_epc, md_old_compare;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_bad = 0;
        m_count = 0; m_compare = 0; m_tirq = 0; m_div = 0; m_req = 0; m_tgt = 0;
      end else begin
        md_old_tirq = m_tirq; md_old_epc = m_epc; md_old_compare = m_compare;
        md_take  = m_valid && !stall_M && !m_req;
        md_ipend = m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 0);
        md_cwe = 0; md_cmpwe = 0;
        m_req = 0;
        if (md_take && (md_ipend || exc_code_M != 0)) begin
          md_code = md_ipend ? 5'd0 : exc_code_M;
          m_cause[6:2] = md_code;
          if (!m_status[1]) begin
            m_epc = bd_M ? pc_M - 32'd4 : pc_M;
            m_cause[31] = bd_M;
          end
          m_status[1] = 1'b1;
          if (md_code == 5'd4 || md_code == 5'd5) m_bad = badvaddr_M;
          m_req = 1; m_tgt = VEC;
        end else if (md_take && eret_M) begin
          m_status[1] = 1'b0;
          m_req = 1; m_tgt = md_old_epc;
        end else if (md_take && cp0_we) begin
          case (cp0_addr)
            5'd9:  md_cwe = 1;
            5'd11: md_cmpwe = 1;
            5'd12: m_status = 32'h0040_0000 | (cp0_wdata & 32'h0000_FF03);
            5'd13: m_cause = (m_cause & ~32'h0000_0300) | (cp0_wdata & 32'h0000_0300);
            5'd14: m_epc = cp0_wdata;
            default: ;
          endcase
        end
        if (md_cwe) begin
          m_count = cp0_wdata; m_div = 0;
        end else begin
          m_div++;
          if (m_div == DIV) begin
            m_div = 0;
            m_count++;
            if (m_count == md_old_compare) m_tirq = 1;
          end
        end
        if (md_cmpwe) begin
          m_compare = cp0_wdata; m_tirq = 0;
        end
        m_cause[15:10] = {md_old_tirq, hw_int[4:0]};
      end
    end
  end

  // ---------------- directed literal expectations ----------------
  // kind: 0 = cp0_rdata masked, 1 = req, 2 = target_pc, 3 = epc_out
  int          d_kind [128];
  logic [31:0] d_mask [128];
  logic [31:0] d_val  [128];
  string       d_name [128];
  int          wr_ptr = 0;
  logic        done = 1'b0;

  task automatic expect_d(input int k, input logic [31:0] mask, input logic [31:0] v,
                          input string nm);
    d_kind[wr_ptr] = k; d_mask[wr_ptr] = mask; d_val[wr_ptr] = v; d_name[wr_ptr] = nm;
    wr_ptr++;
  endtask

  // ---------------- compare process ----------------
  int n_assert = 0, n_fail = 0, rd_ptr = 0;
  logic [31:0] act;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_assert++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, a, e);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("req", {31'b0, req}, {31'b0, m_req});
        if (m_req) chk("target_pc", target_pc, m_tgt);
        chk("epc_out", epc_out, m_epc);
        chk($sformatf("cp0_rdata[%0d]", cp0_addr), cp0_rdata, model_read(cp0_addr));
      end
      while (rd_ptr != wr_ptr) begin
        case (d_kind[rd_ptr])
          0:       act = cp0_rdata & d_mask[rd_ptr];
          1:       act = {31'b0, req};
          2:       act = target_pc;
          default: act = epc_out;
        endcase
        chk(d_name[rd_ptr], act, d_val[rd_ptr]);
        rd_ptr++;
      end
      if (done) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_valid = 0; stall_M = 0; exc_code_M = 0; eret_M = 0; cp0_we = 0; bd_M = 0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] mask, input logic [31:0] v,
                    input string nm);
    cp0_addr = a;
    expect_d(0, mask, v, nm);
    cyc();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    m_valid = 1; cp0_we = 1; cp0_addr = a; cp0_wdata = d;
    cyc();
    idle();
  endtask

  logic [4:0] exc_tab [12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                               5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
  logic [4:0] addr_tab [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd15};

  initial begin
    idle();
    hw_int = 0; cp0_addr = 5'd12; cp0_wdata = 0; pc_M = 0; badvaddr_M = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // reset state and Count rate
    expect_d(0, 32'hFFFF_FFFF, 32'h0040_0000, "status_reset");
    expect_d(1, 32'h1, 32'h0, "req_reset");
    cyc(); cyc();
    rd(5'd9, 32'hFFFF_FFFF, 32'd1, "count_after_2");
    cyc();
    rd(5'd9, 32'hFFFF_FFFF, 32'd2, "count_after_4");

    // Ov in a delay slot
    m_valid = 1; exc_code_M = 5'd12; pc_M = 32'h8000_0010; bd_M = 1;
    cyc(); idle();
    expect_d(1, 32'h1, 32'h1, "req_ov");
    expect_d(2, 32'hFFFF_FFFF, VEC, "target_ov");
    cyc();
    rd(5'd14, 32'hFFFF_FFFF, 32'h8000_000C, "epc_bd");
    rd(5'd13, 32'h8000_007C, 32'h8000_0030, "cause_bd_code12");
    rd(5'd12, 32'h2, 32'h2, "exl_set");

    // AdEL at EXL=1: BadVAddr latched, EPC kept
    m_valid = 1; exc_code_M = 5'd4; badvaddr_M = 32'h8000_0003; pc_M = 32'h8000_0200;
    cyc(); idle(); cyc();
    rd(5'd8, 32'hFFFF_FFFF, 32'h8000_0003, "badvaddr_adel");
    m_valid = 1; exc_code_M = 5'd12; pc_M = 32'h8000_0300;
    cyc(); idle(); cyc();
    rd(5'd14, 32'hFFFF_FFFF, 32'h8000_000C, "epc_kept_nested");

    // interrupt beats a same-cycle mtc0 to EPC
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'b000001;
    cyc();
    m_valid = 1; pc_M = 32'h8000_0400; cp0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
    cyc(); idle(); hw_int = 0;
    expect_d(1, 32'h1, 32'h1, "req_int");
    expect_d(2, 32'hFFFF_FFFF, VEC, "target_int");
    cyc();
    rd(5'd14, 32'hFFFF_FFFF, 32'h8000_0400, "epc_int_not_mtc0");
    rd(5'd13, 32'h0000_007C, 32'h0, "code_int");

    // eret, with a wrong-path instruction in the flush cycle
    mtc0(5'd14, 32'h8000_0100);
    m_valid = 1; eret_M = 1;
    cyc(); idle();
    expect_d(1, 32'h1, 32'h1, "req_eret");
    expect_d(2, 32'hFFFF_FFFF, 32'h8000_0100, "target_eret");
    m_valid = 1; exc_code_M = 5'd10; pc_M = 32'h8000_0500;
    cyc(); idle();
    expect_d(1, 32'h1, 32'h0, "flush_one_cycle");
    rd(5'd12, 32'h2, 32'h0, "exl_cleared");
    rd(5'd13, 32'h0000_007C, 32'h0, "wrong_path_ignored");

    // hw_int dropped before the commit cycle: no interrupt
    hw_int = 6'b000001; cyc();
    hw_int = 0; cyc();
    m_valid = 1; pc_M = 32'h8000_0600;
    cyc(); idle();
    expect_d(1, 32'h1, 32'h0, "no_int_after_deassert");
    cyc();

    // timer match, acknowledge, wrap
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    repeat (14) cyc();
    rd(5'd13, 32'h0000_8000, 32'h0000_8000, "ip7_set");
    mtc0(5'd11, 32'd100);
    cyc();
    rd(5'd13, 32'h0000_8000, 32'h0, "ip7_cleared");
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "count_max");
    cyc();
    rd(5'd9, 32'hFFFF_FFFF, 32'h0, "count_wrap");

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      m_valid    = ($urandom_range(0, 3) != 0);
      stall_M    = ($urandom_range(0, 4) == 0);
      exc_code_M = exc_tab[$urandom_range(0, 11)];
      eret_M     = ($urandom_range(0, 7) == 0);
      cp0_we     = ($urandom_range(0, 2) == 0);
      cp0_addr   = addr_tab[$urandom_range(0, 7)];
      cp0_wdata  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
      pc_M       = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      bd_M       = $urandom_range(0, 1) != 0;
      badvaddr_M = $urandom;
      if ($urandom_range(0, 5) == 0) hw_int = 6'($urandom_range(0, 63));
      cyc();
    end
    idle(); hw_int = 0; cyc();

    // async reset in the middle of a flush
    m_valid = 1; exc_code_M = 5'd8; pc_M = 32'h8000_0700;
    cyc(); idle();
    #1 rst_n = 0;
    expect_d(1, 32'h1, 32'h0, "req_async_reset");
    cyc();
    rst_n = 1;
    rd(5'd12, 32'hFFFF_FFFF, 32'h0040_0000, "status_after_reset");
    done = 1;
  end

endmodule
